// File: rtl/control_unit.sv
// control_unit: combinational decode from state/opcode/z; state, illegal and icount are registered.
// Outputs follow opcode in the same cycle; no backpressure. Macro UC_INSTR_COUNT_EN enables icount.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        z,
  input  logic        resume,
  output logic        s_abs,
  output logic        s_inc,
  output logic        s_inm,
  output logic        we3,
  output logic        wez,
  output logic [2:0]  op,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] icount
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALT   = 2'd1,
    ST_RESUME = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_illegal_op;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    s_abs        = 1'b1;
    s_inc        = 1'b1;
    s_inm        = 1'b0;
    we3          = 1'b0;
    wez          = 1'b0;
    op           = 3'b000;
    halted       = 1'b0;
    w_illegal_op = 1'b0;
    case (r_state)
      ST_RUN: begin
        casez (opcode)
          6'b0?????: begin
            op  = opcode[4:2];
            we3 = 1'b1;
            wez = 1'b1;
          end
          6'b1000??: begin
            we3   = 1'b1;
            s_inm = 1'b1;
          end
          6'b110000: s_abs = 1'b0;
          6'b110001: s_abs = ~z;
          6'b110010: s_abs = z;
          6'b110011: s_inc = 1'b0;
          6'b111110: begin
            w_next = ST_RUN;
          end
          // HALT word carries a zero offset, so the relative path holds the PC in place
          6'b111111: begin
            s_inc  = 1'b0;
            w_next = ST_HALT;
          end
          default: w_illegal_op = 1'b1;
        endcase
      end
      ST_HALT: begin
        s_inc  = 1'b0;
        halted = 1'b1;
        if (resume) w_next = ST_RESUME;
      end
      ST_RESUME: w_next = ST_RUN;
      default:   w_next = ST_RUN;
    endcase
    // Writes must stay off while reset is held, whatever opcode the datapath presents
    if (!reset) begin
      s_abs  = 1'b1;
      s_inc  = 1'b1;
      s_inm  = 1'b0;
      we3    = 1'b0;
      wez    = 1'b0;
      op     = 3'b000;
      halted = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            r_illegal <= 1'b0;
    else if (w_illegal_op) r_illegal <= 1'b1;
  end

  assign illegal = r_illegal;

`ifdef UC_INSTR_COUNT_EN
  logic [15:0] r_icount;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_icount <= 16'h0000;
    else if ((r_state == ST_RUN) && (r_icount != 16'hFFFF))
      r_icount <= r_icount + 16'd1;
  end

  assign icount = r_icount;
`else
  assign icount = 16'h0000;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Randomized + directed bench for control_unit with a queue scoreboard and an ISA-level reference model.
// Driver pushes expected outputs per cycle; monitor pops and compares on the falling edge.
module tb_control_unit;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic        z;
  logic        resume;
  logic        s_abs, s_inc, s_inm, we3, wez, halted, illegal;
  logic [2:0]  op;
  logic [15:0] icount;

  control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .resume(resume),
    .s_abs(s_abs), .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez),
    .op(op), .halted(halted), .illegal(illegal), .icount(icount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        s_abs;
    logic        s_inc;
    logic        s_inm;
    logic        we3;
    logic        wez;
    logic [2:0]  op;
    logic        halted;
    logic        illegal;
    logic [15:0] icount;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   drv_done = 0;

  // Reference model: processor mode plus sticky flag and retired-word count
  int   m_mode;          // 0 running, 1 halted, 2 stepping past the halt word
  bit   m_illegal;
  int   m_count;

  function automatic bit is_legal(input logic [5:0] o);
    if (o[5] == 1'b0)                       return 1;
    if (o[5:2] == 4'b1000)                  return 1;
    if (o >= 6'b110000 && o <= 6'b110011)   return 1;
    if (o == 6'b111110 || o == 6'b111111)   return 1;
    return 0;
  endfunction

  function automatic exp_t expected(input logic [5:0] o, input logic zz, input logic rst);
    exp_t e;
    e = '0;
    e.s_abs = 1'b1;
    e.s_inc = 1'b1;
    e.illegal = m_illegal;
    e.icount  = 16'(m_count);
    if (!rst) return e;
    if (m_mode == 1) begin
      e.s_inc = 1'b0;
      e.halted = 1'b1;
    end else if (m_mode == 0) begin
      if (o[5] == 1'b0) begin
        e.op = o[4:2]; e.we3 = 1'b1; e.wez = 1'b1;
      end else if (o[5:2] == 4'b1000) begin
        e.we3 = 1'b1; e.s_inm = 1'b1;
      end else if (o == 6'b110000) begin
        e.s_abs = 1'b0;
      end else if (o == 6'b110001) begin
        e.s_abs = (zz == 1'b1) ? 1'b0 : 1'b1;
      end else if (o == 6'b110010) begin
        e.s_abs = (zz == 1'b0) ? 1'b0 : 1'b1;
      end else if (o == 6'b110011 || o == 6'b111111) begin
        e.s_inc = 1'b0;
      end
    end
    return e;
  endfunction

  task automatic step(input logic [5:0] o, input logic zz, input logic res, input logic rst);
    @(posedge clk);
    #1;
    opcode = o; z = zz; resume = res; reset = rst;
    if (!rst) begin
      m_mode = 0; m_illegal = 0; m_count = 0;
    end
    exp_q.push_back(expected(o, zz, rst));
    if (rst) begin
      case (m_mode)
        0: begin
`ifdef UC_INSTR_COUNT_EN
          if (m_count < 65535) m_count = m_count + 1;
`endif
          if (!is_legal(o)) m_illegal = 1;
          if (o == 6'b111111) m_mode = 1;
        end
        1: if (res) m_mode = 2;
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("s_abs",   16'(s_abs),   16'(e.s_abs));
        chk("s_inc",   16'(s_inc),   16'(e.s_inc));
        chk("s_inm",   16'(s_inm),   16'(e.s_inm));
        chk("we3",     16'(we3),     16'(e.we3));
        chk("wez",     16'(wez),     16'(e.wez));
        chk("op",      16'(op),      16'(e.op));
        chk("halted",  16'(halted),  16'(e.halted));
        chk("illegal", 16'(illegal), 16'(e.illegal));
        chk("icount",  icount,       e.icount);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [5:0] o;
    int r;
    reset = 1'b0; opcode = 6'b000100; z = 1'b0; resume = 1'b0;
    m_mode = 0; m_illegal = 0; m_count = 0;

    // Reset with an ALU opcode present, then release
    step(6'b000100, 1'b0, 1'b0, 1'b0);
    step(6'b000100, 1'b0, 1'b0, 1'b0);
    step(6'b000100, 1'b0, 1'b0, 1'b1);
    // Conditional jump both ways
    step(6'b110001, 1'b1, 1'b0, 1'b1);
    step(6'b110001, 1'b0, 1'b0, 1'b1);
    step(6'b110010, 1'b0, 1'b0, 1'b1);
    step(6'b110000, 1'b1, 1'b0, 1'b1);
    // HALT with resume ignored on the decode cycle, hold, resume, step, run
    step(6'b111111, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) step(6'b000000, 1'b1, 1'b0, 1'b1);
    step(6'b000000, 1'b0, 1'b1, 1'b1);
    step(6'b000000, 1'b0, 1'b1, 1'b1);
    step(6'b000000, 1'b0, 1'b0, 1'b1);
    // Sticky illegal, then cleared by reset
    step(6'b101010, 1'b0, 1'b0, 1'b1);
    step(6'b000000, 1'b0, 1'b0, 1'b1);
    step(6'b100000, 1'b0, 1'b0, 1'b1);
    step(6'b111110, 1'b0, 1'b0, 1'b1);
    step(6'b111110, 1'b0, 1'b0, 1'b0);
    step(6'b111110, 1'b0, 1'b0, 1'b1);
    // Load-immediate and relative branch
    step(6'b100011, 1'b0, 1'b0, 1'b1);
    step(6'b110011, 1'b0, 1'b0, 1'b1);
    // Reset mid-HALT, then mid-RESUME
    step(6'b111111, 1'b0, 1'b0, 1'b1);
    step(6'b010100, 1'b0, 1'b0, 1'b1);
    step(6'b010100, 1'b0, 1'b0, 1'b0);
    step(6'b010100, 1'b0, 1'b0, 1'b1);
    step(6'b111111, 1'b0, 1'b0, 1'b1);
    step(6'b010100, 1'b0, 1'b1, 1'b1);
    step(6'b010100, 1'b0, 1'b0, 1'b0);
    step(6'b010100, 1'b0, 1'b0, 1'b1);
    step(6'b010100, 1'b0, 1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40)      o = {1'b0, 5'($urandom)};
      else if (r < 50) o = {4'b1000, 2'($urandom)};
      else if (r < 65) o = {4'b1100, 2'($urandom)};
      else if (r < 72) o = 6'b111110;
      else if (r < 77) o = 6'b111111;
      else             o = 6'($urandom);
      step(o, 1'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 99) != 0));
    end

`ifdef UC_INSTR_COUNT_EN
    // Long run to reach counter saturation
    step(6'b111110, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++)
      step({1'b0, 5'($urandom)}, 1'($urandom), 1'($urandom), 1'b1);
`endif

    drv_done = 1;
    repeat (2) @(negedge clk);
    chk("scoreboard_drain", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  async active-low reset
- opcode  in  6  instruction bits [15:10] from datapath
- z  in  1  registered zero flag from datapath
- resume  in  1  single-cycle pulse, leave HALT
- s_abs  out  1  PC mux select: 0 = absolute target, 1 = adder
- s_inc  out  1  adder mux select: 0 = relative offset, 1 = +1
- s_inm  out  1  write-data mux select: 0 = ALU, 1 = immediate
- we3  out  1  register file write enable
- wez  out  1  Z flag write enable
- op  out  3  ALU operation
- halted  out  1  high in HALT state
- illegal  out  1  sticky illegal-opcode flag
- icount  out  16  retired instruction count

Function
REQ-003 Decode SHALL be combinational from state, opcode and z; only state, illegal and icount are registered.
REQ-004 Sequential default: s_abs=1, s_inc=1, s_inm=0, we3=0, wez=0, op=000.
REQ-005 opcode 0ooo-xx (bit5=0) is ALU: op=opcode[4:2], we3=1, wez=1, s_inm=0, sequential.
REQ-006 opcode 1000xx is load-immediate: we3=1, s_inm=1, wez=0, sequential.
REQ-007 110000 J: s_abs=0. 110001 JZ: s_abs=0 if z=1, else sequential. 110010 JNZ: s_abs=0 if z=0, else sequential.
REQ-008 110011 BR (relative): s_abs=1, s_inc=0.
REQ-009 111110 NOP: sequential, no writes.
REQ-010 111111 HALT: s_abs=1, s_inc=0, no writes. Offset bits [9:0] are 0 by ISA rule, so PC self-loops. Next state is HALT.
REQ-011 Every other opcode is illegal: behaves as NOP and sets illegal=1 on that clock edge.
REQ-012 States: RUN, HALT, RESUME.
- RUN -> HALT on HALT opcode.
- HALT -> RESUME on resume=1.
- RESUME -> RUN unconditionally.
REQ-013 In HALT: s_abs=1, s_inc=0, we3=0, wez=0, halted=1, regardless of opcode or z.
REQ-014 In RESUME: sequential default outputs for one cycle, stepping PC past the HALT word; halted=0.
REQ-015 resume SHALL be ignored in RUN and RESUME, including the cycle in which HALT is decoded.
REQ-016 icount SHALL increment by 1 on each RUN-state edge, including HALT/NOP/illegal words, and saturate at 16'hFFFF. It does not count in HALT or RESUME.
REQ-017 illegal SHALL remain 1 until reset.

Reset
REQ-018 While reset=0: state=RUN, illegal=0, icount=0, halted=0, we3=0, wez=0, all other outputs at sequential default.
REQ-019 Reset asserted mid-HALT or mid-RESUME SHALL return the block to RUN on deassertion, with no RESUME step.

Configuration
REQ-020 Macro UC_INSTR_COUNT_EN: defined -> icount counter is implemented per REQ-016; undefined -> no counter flops and icount is tied to 16'h0000.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset low, opcode=000100 -> we3=0, wez=0, icount=0; release -> we3=1, wez=1, op=001.
- opcode=110001, z=1 -> s_abs=0; z=0 -> s_abs=1, s_inc=1.
- opcode=111111 in RUN -> next cycle halted=1. Hold 5 cycles with opcode=000000 -> we3=0. resume pulse -> one RESUME cycle with s_inc=1, then RUN.
- opcode=101010 -> illegal=1 after edge, we3=0; then legal opcodes -> illegal stays 1 until reset.
- UC_INSTR_COUNT_EN defined, 70000 RUN cycles -> icount=16'hFFFF. Undefined -> icount=0 throughout.
- opcode=100011 -> s_inm=1, we3=1, wez=0; opcode=110011 -> s_abs=1, s_inc=0.
